// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} ld_state_e;

    localparam int DEF_ADDR_W = 14;
    localparam int MAX_WORDS  = (1 << DEF_ADDR_W) / 4;

    function automatic int max_words(input int addr_w);
        return (1 << addr_w) / 4;
    endfunction

    // Rounded clocks-per-bit.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// valid / framing-error pulses at the stop-bit sample.
module uart_rx #(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

    localparam int            CW      = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        sync1_d = rx_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = R_START;
            end
            R_START: if (cnt_q == HALF_M1) begin
                // A start bit that is high again at mid-bit was a glitch.
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL_M1) begin
                cnt_d   = '0;
                shift_d = {sync2_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = R_STOP;
            end
            R_STOP: if (cnt_q == FULL_M1) begin
                state_d = R_IDLE;
                valid_d = sync2_q;
                ferr_d  = !sync2_q;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= R_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = shift_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a framed program image over UART and writes it into
// instruction memory while holding the CPU pipeline in reset.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          DIV  = calc_div(CLK_FREQ, BAUD);
    localparam logic [16:0] MAXW = 17'(max_words(ADDR_W));

    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr;

    uart_rx #(.DIV(DIV)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    ld_state_e         state_q, state_d;
    logic [7:0]        nlo_q, nlo_d, csum_q, csum_d;
    logic [15:0]       nwords_q, nwords_d, wcnt_q, wcnt_d, hdr_n;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d;

    always_comb begin
        state_d  = state_q;
        nlo_d    = nlo_q;
        csum_d   = csum_q;
        nwords_d = nwords_q;
        wcnt_d   = wcnt_q;
        bidx_d   = bidx_q;
        wbuf_d   = wbuf_q;
        we_d     = 1'b0;
        addr_d   = we_q ? addr_q + ADDR_W'(4) : addr_q;
        wdata_d  = wdata_q;
        hdr_n    = {rx_data, nlo_q};
        case (state_q)
            // start wins over any byte arriving in the same cycle
            IDLE, DONE, ERR: if (start) begin
                state_d = HDR0;
                addr_d  = '0;
            end
            HDR0: if (rx_ferr) state_d = ERR;
                  else if (rx_valid) begin
                      nlo_d   = rx_data;
                      state_d = HDR1;
                  end
            HDR1: if (rx_ferr) state_d = ERR;
                  else if (rx_valid) begin
                      nwords_d = hdr_n;
                      wcnt_d   = '0;
                      bidx_d   = '0;
                      csum_d   = '0;
                      state_d  = (hdr_n == 16'd0 || {1'b0, hdr_n} > MAXW) ? ERR : DATA;
                  end
            DATA: if (rx_ferr) state_d = ERR;
                  else if (rx_valid) begin
                      csum_d = csum_q ^ rx_data;
                      wbuf_d = {rx_data, wbuf_q[23:8]};
                      bidx_d = bidx_q + 2'd1;
                      if (bidx_q == 2'd3) begin
                          we_d    = 1'b1;
                          wdata_d = {rx_data, wbuf_q};
                          wcnt_d  = wcnt_q + 16'd1;
                          if (wcnt_d == nwords_q) state_d = CSUM;
                      end
                  end
            CSUM: if (rx_ferr) state_d = ERR;
                  else if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERR;
            default: state_d = IDLE;
        endcase
        busy_d      = state_d inside {HDR0, HDR1, DATA, CSUM};
        cpu_rst_n_d = state_d inside {IDLE, DONE};
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nlo_q       <= '0;
            csum_q      <= '0;
            nwords_q    <= '0;
            wcnt_q      <= '0;
            bidx_q      <= '0;
            wbuf_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nlo_q       <= nlo_d;
            csum_q      <= csum_d;
            nwords_q    <= nwords_d;
            wcnt_q      <= wcnt_d;
            bidx_q      <= bidx_d;
            wbuf_q      <= wbuf_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader at DIV=10.
module tb_uart_imem_loader;

    localparam int DIV = 10;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, uart_rx = 1'b1;
    logic        imem_we, cpu_rst_n, busy, done, err;
    logic [13:0] imem_addr;
    logic [31:0] imem_wdata;

    uart_imem_loader #(.CLK_FREQ(1_152_000), .BAUD(115200), .ADDR_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed { logic [13:0] a; logic [31:0] d; } wr_t;
    wr_t         exp_q[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, wr_cnt = 0, rise_cyc = -1;
    logic [13:0] exp_addr = '0;
    logic [7:0]  cs;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor + cpu_rst_n rise timestamp.
    initial begin
        logic cpu_prev;
        wr_t  e;
        cpu_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (imem_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) check("unexpected_we", imem_we, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    check("imem_addr", imem_addr, e.a);
                    check("imem_wdata", imem_wdata, e.d);
                end
            end
            if (!cpu_prev && cpu_rst_n) rise_cyc = cyc;
            cpu_prev = cpu_rst_n;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            tick(DIV);
        end
        uart_rx = 1'b1;
    endtask

    task automatic do_start(input bit chk_it);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (chk_it) begin
            exp_addr = '0;
            check("start_busy", busy, 1'b1);
            check("start_cpu_rst_n", cpu_rst_n, 1'b0);
        end
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
        cs = '0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                exp_q.push_back({exp_addr, w});
                exp_addr += 14'd4;
            end
            cs ^= w[8*k +: 8];
            send_byte(w[8*k +: 8], 1'b1);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_we"}, imem_we, 1'b0);
        check({tag, "_addr"}, imem_addr, 14'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        int base, csum_cyc;
        #1 rst_n = 1'b0;
        tick(3);
        check_idle_reset("reset");
        rst_n = 1'b1;
        tick(3);

        // Good two-word frame
        do_start(1);
        base = wr_cnt;
        send_hdr(16'd2);
        send_word(32'h00500093);
        send_word(32'h00108113);
        csum_cyc = cyc;
        send_byte(cs, 1'b1);
        tick(2);
        check("good_done", done, 1'b1);
        check("good_err", err, 1'b0);
        check("good_busy", busy, 1'b0);
        check("good_cpu_rst_n", cpu_rst_n, 1'b1);
        check("good_rise_cycle", rise_cyc, csum_cyc + 99);
        check("good_writes", wr_cnt - base, 2);

        // Checksum off by one
        do_start(1);
        base = wr_cnt;
        send_hdr(16'd2);
        send_word(32'h00500093);
        send_word(32'h00108113);
        send_byte(cs + 8'd1, 1'b1);
        tick(2);
        check("badcs_err", err, 1'b1);
        check("badcs_done", done, 1'b0);
        check("badcs_cpu_rst_n", cpu_rst_n, 1'b0);
        check("badcs_writes", wr_cnt - base, 2);

        // Header N=0 and N=0x1001
        do_start(1);
        base = wr_cnt;
        send_hdr(16'h0000);
        tick(2);
        check("n0_err", err, 1'b1);
        check("n0_busy", busy, 1'b0);
        do_start(1);
        send_hdr(16'h1001);
        tick(2);
        check("n1001_err", err, 1'b1);
        check("n1001_busy", busy, 1'b0);
        check("hdr_no_we", wr_cnt - base, 0);

        // Framing error on data byte 2
        do_start(1);
        base = wr_cnt;
        send_hdr(16'd2);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        tick(2);
        check("ferr_err", err, 1'b1);
        check("ferr_done", done, 1'b0);
        check("ferr_busy", busy, 1'b0);
        check("ferr_no_we", wr_cnt - base, 0);

        // Async reset after 5 of 8 data bytes, then a clean reload
        do_start(1);
        send_hdr(16'd2);
        send_word(32'hA5A5_1234);
        send_byte(8'h77, 1'b1);
        tick(1);
        rst_n = 1'b0;
        #1;
        check_idle_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        do_start(1);
        send_hdr(16'd2);
        send_word(32'hDEADBEEF);
        send_word(32'h12345678);
        send_byte(cs, 1'b1);
        tick(2);
        check("reload_done", done, 1'b1);
        check("reload_err", err, 1'b0);

        // Glitch in HDR0 is ignored; second start during DATA is ignored
        do_start(1);
        tick(5);
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(20);
        check("glitch_busy", busy, 1'b1);
        check("glitch_err", err, 1'b0);
        send_hdr(16'd2);
        send_word(32'hCAFEF00D);
        do_start(0);
        check("restart_ignored_busy", busy, 1'b1);
        send_word(32'h0BADC0DE);
        send_byte(cs, 1'b1);
        tick(2);
        check("glitch_done", done, 1'b1);
        check("glitch_err_end", err, 1'b0);
        check("glitch_cpu_rst_n", cpu_rst_n, 1'b1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Boot-time program loader sitting directly upstream of the instruction-fetch stage. It receives a framed program image over a UART line, assembles little-endian 32-bit words and writes them into instruction memory through a write port shared with the fetch path. While loading, it holds the pipeline in reset, then releases it so fetch restarts from address 0.

## Interface
- CLK_FREQ, 25_000_000: clock frequency in Hz.
- BAUD, 115200: UART bit rate.
- ADDR_W, 14: instruction-memory byte-address width, matching the fetch PC width.
- clk  in  1  pipeline clock (cpuclk domain).
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle synchronous pulse (debounced button) that arms a load.
- uart_rx  in  1  asynchronous serial input, idle high; double-flop synchronised internally.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the word being written, word-aligned.
- imem_wdata  out  32  word being written.
- cpu_rst_n  out  1  active-low hold for the IF/ID/EX/MEM/WB pipeline.
- busy  out  1  load in progress.
- done  out  1  sticky: last load completed with a good checksum.
- err  out  1  sticky: last load failed (header, framing or checksum).

## Operation
- Frame format: N_lo, N_hi (word count, little-endian 16 bit), then 4·N data bytes with each word LSB-first, then one checksum byte equal to the XOR of all 4·N data bytes.
- Valid N is 1..2^ADDR_W/4 (4096 by default). N=0 or N>4096 → ERR immediately after N_hi.
- FSM states:
  - IDLE -start→ HDR0.
  - HDR0 -byte→ HDR1.
  - HDR1 -byte→ DATA or ERR.
  - DATA: after 4·N bytes → CSUM.
  - CSUM -byte→ DONE if the checksum matches, else ERR.
  - DONE/ERR -start→ HDR0.
- start is ignored in HDR0/HDR1/DATA/CSUM.
- A framing error (stop bit sampled low) in any receive state → ERR; that byte is discarded.
- Word assembly: byte k of a word goes to bits [8k+7:8k]. After byte 3, issue imem_we for one cycle, then advance imem_addr by 4. imem_addr resets to 0 on each start.
- Outputs by state:
  - cpu_rst_n is 0 in HDR0..CSUM and in ERR, and 1 in IDLE and DONE.
  - busy is 1 in HDR0..CSUM.
  - done/err are cleared on start and set on entry to DONE/ERR.
- UART RX: DIV = round(CLK_FREQ/BAUD).
  - A falling edge on the synchronised line starts a bit counter.
  - The start bit is re-checked at DIV/2; if it is high, the event is a glitch and the receiver returns to idle.
  - Data bits are sampled every DIV cycles thereafter, LSB first, followed by the stop bit.
  - A one-cycle rx_valid or rx_ferr pulse is produced at the stop-bit sample.

## Timing
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=1, busy=0, done=0, err=0, FSM=IDLE, RX idle.
- start → busy=1 and cpu_rst_n=0 on the next clock edge.
- rx_valid of the 4th byte of a word at cycle t → imem_we=1 at t+1, with imem_addr/imem_wdata valid the same cycle. imem_addr increments at t+2.
- Checksum byte rx_valid at t → done or err=1 and cpu_rst_n updated at t+1. The pipeline's first fetch of address 0 occurs after cpu_rst_n rises.
- Input latency: 2 synchroniser cycles are added to every uart_rx edge.
- Async reset mid-load: immediate return to reset values. Memory keeps its partially written contents, and cpu_rst_n=1 releases the CPU on that partial image (documented behaviour).
- A start arriving in the same cycle as rx_valid in DONE/ERR: start wins and the byte is dropped.

## Structure
- Package loader_pkg holds:
  - the state enum (IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR);
  - MAX_WORDS = 2^ADDR_W/4;
  - the DIV computation function.
- Sub-module uart_rx contains the synchroniser, bit timer and shift register, and outputs rx_data[7:0], rx_valid and rx_ferr. The top-level holds the FSM, word assembler, byte counter and checksum.

## Test plan
- Bench settings: CLK_FREQ=1_152_000 and BAUD=115200, giving DIV=10.
- N=2, data 0x00500093, 0x00108113, correct checksum:
  - imem writes (0x0000, 0x00500093) then (0x0004, 0x00108113);
  - done=1, err=0, cpu_rst_n rises one cycle after the checksum byte.
- Same frame with the checksum byte off by 1: two writes occur, err=1, done=0, cpu_rst_n stays 0.
- Header N=0x0000 → err=1 right after N_hi, no imem_we. Header N=0x1001 → same result.
- Stop bit forced low on data byte 2 → err=1, no write for that word, busy=0.
- Assert rst_n=0 after 5 of 8 data bytes: all outputs return to reset values within the same cycle. A fresh start plus a full frame then loads correctly from address 0.
- 4-cycle low glitch on uart_rx while idle in HDR0: no byte is received. A second start pulse during DATA is ignored, and the load completes with done=1.
